// File: rtl/cpu_control_fsm.sv
// Control sequencer for the 16-bit CPU: fetch, PC update, decode, execute, memory access, halt.
// Define CPU_CALL_RET_EN to decode opcode 010 as BL / BX / BLX and to add the pc_from_c port.
module cpu_control_fsm #(
  parameter int         STATE_W    = 5,
  parameter logic [1:0] MCMD_NONE  = 2'b00,
  parameter logic [1:0] MCMD_READ  = 2'b01,
  parameter logic [1:0] MCMD_WRITE = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       N,
  input  logic       V,
  input  logic       Z,
  output logic       reset_pc,
  output logic       load_pc,
  output logic       pc_sel,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       load_ir,
  output logic       load_addr,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
`ifdef CPU_CALL_RET_EN
  output logic       pc_from_c,
`endif
  output logic       halted
);

  localparam logic [2:0] NSEL_RN = 3'b001;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b100;
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    RST, IF1, IF2, UPDATE_PC, DECODE, WR_IMM, GET_A, GET_B, GET_BD,
    EXEC, EXEC_CMP, WR_REG, ADDR_CALC, LOAD_ADDR, MEM_RD1, MEM_RD2,
    STR_C, MEM_WR, BRANCH,
`ifdef CPU_CALL_RET_EN
    BL_LINK, BX_GET, BX_C, BX_PC,
`endif
    HALT
  } state_t;

  state_t     state_reg, state_next;
  logic [4:0] instr;
  logic       taken;

  assign instr = {opcode, op};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= RST;
    else       state_reg <= state_next;
  end

  // Branch condition from the status flags; only consumed in BRANCH.
  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b000:  taken = 1'b1;
      3'b001:  taken = Z;
      3'b010:  taken = ~Z;
      3'b011:  taken = N ^ V;
      3'b100:  taken = (N ^ V) | Z;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    reset_pc   = 1'b0;
    load_pc    = 1'b0;
    pc_sel     = 1'b0;
    addr_sel   = 1'b0;
    mem_cmd    = MCMD_NONE;
    load_ir    = 1'b0;
    load_addr  = 1'b0;
    nsel       = 3'b000;
    vsel       = VSEL_C;
    write      = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    halted     = 1'b0;
`ifdef CPU_CALL_RET_EN
    pc_from_c  = 1'b0;
`endif
    case (state_reg)
      RST: begin
        reset_pc   = 1'b1;
        load_pc    = 1'b1;
        state_next = IF1;
      end
      IF1: begin
        addr_sel   = 1'b1;
        mem_cmd    = MCMD_READ;
        state_next = IF2;
      end
      IF2: begin
        addr_sel   = 1'b1;
        mem_cmd    = MCMD_READ;
        load_ir    = 1'b1;
        state_next = UPDATE_PC;
      end
      UPDATE_PC: begin
        load_pc    = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        casez (instr)
          5'b110_10: state_next = WR_IMM;
          5'b110_00: state_next = GET_B;
          5'b101_11: state_next = GET_B;
          5'b101_??: state_next = GET_A;
          5'b011_00: state_next = GET_A;
          5'b100_00: state_next = GET_A;
          5'b111_??: state_next = HALT;
          5'b001_??: state_next = BRANCH;
`ifdef CPU_CALL_RET_EN
          5'b010_11: state_next = BL_LINK;
          5'b010_10: state_next = BL_LINK;
          5'b010_00: state_next = BX_GET;
`endif
          default:   state_next = IF1;
        endcase
      end
      WR_IMM: begin
        nsel       = NSEL_RN;
        vsel       = VSEL_IMM;
        write      = 1'b1;
        state_next = IF1;
      end
      GET_A: begin
        nsel       = NSEL_RN;
        loada      = 1'b1;
        state_next = (opcode == 3'b101) ? GET_B : ADDR_CALC;
      end
      GET_B: begin
        nsel       = NSEL_RM;
        loadb      = 1'b1;
        state_next = (instr == 5'b101_01) ? EXEC_CMP : EXEC;
      end
      EXEC: begin
        loadc      = 1'b1;
        asel       = (instr == 5'b110_00);  // MOV reg passes B through 0 + B
        state_next = WR_REG;
      end
      EXEC_CMP: begin
        loads      = 1'b1;
        state_next = IF1;
      end
      WR_REG: begin
        nsel       = NSEL_RD;
        vsel       = VSEL_C;
        write      = 1'b1;
        state_next = IF1;
      end
      ADDR_CALC: begin
        bsel       = 1'b1;
        loadc      = 1'b1;
        state_next = LOAD_ADDR;
      end
      LOAD_ADDR: begin
        load_addr  = 1'b1;
        state_next = (opcode == 3'b100) ? GET_BD : MEM_RD1;
      end
      MEM_RD1: begin
        mem_cmd    = MCMD_READ;
        state_next = MEM_RD2;
      end
      MEM_RD2: begin
        mem_cmd    = MCMD_READ;
        nsel       = NSEL_RD;
        vsel       = VSEL_MDATA;
        write      = 1'b1;
        state_next = IF1;
      end
      GET_BD: begin
        nsel       = NSEL_RD;
        loadb      = 1'b1;
        state_next = STR_C;
      end
      STR_C: begin
        asel       = 1'b1;
        loadc      = 1'b1;
        state_next = MEM_WR;
      end
      MEM_WR: begin
        mem_cmd    = MCMD_WRITE;
        state_next = IF1;
      end
      BRANCH: begin
        load_pc    = taken;
        pc_sel     = taken;
        state_next = IF1;
      end
`ifdef CPU_CALL_RET_EN
      BL_LINK: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_PC;
        write = 1'b1;
        // BL jumps in the same cycle; BLX continues into the register-target path.
        if (op == 2'b11) begin
          load_pc    = 1'b1;
          pc_sel     = 1'b1;
          state_next = IF1;
        end else begin
          state_next = BX_GET;
        end
      end
      BX_GET: begin
        nsel       = NSEL_RD;
        loadb      = 1'b1;
        state_next = BX_C;
      end
      BX_C: begin
        asel       = 1'b1;
        loadc      = 1'b1;
        state_next = BX_PC;
      end
      BX_PC: begin
        load_pc    = 1'b1;
        pc_sel     = 1'b1;
        pc_from_c  = 1'b1;
        state_next = IF1;
      end
`endif
      HALT: begin
        halted     = 1'b1;
        state_next = HALT;
      end
      default: state_next = RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized bench for cpu_control_fsm: a per-mnemonic micro-op table predicts every cycle's outputs.
module tb_cpu_control_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = '0;
  logic [1:0] op = '0;
  logic [2:0] cond = '0;
  logic       N = 1'b0, V = 1'b0, Z = 1'b0;
  logic       reset_pc, load_pc, pc_sel, addr_sel, load_ir, load_addr;
  logic [1:0] mem_cmd, vsel;
  logic [2:0] nsel;
  logic       write, loada, loadb, loadc, loads, asel, bsel, halted;
`ifdef CPU_CALL_RET_EN
  logic       pc_from_c;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  cpu_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
    .N(N), .V(V), .Z(Z),
    .reset_pc(reset_pc), .load_pc(load_pc), .pc_sel(pc_sel), .addr_sel(addr_sel),
    .mem_cmd(mem_cmd), .load_ir(load_ir), .load_addr(load_addr), .nsel(nsel),
    .vsel(vsel), .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel),
`ifdef CPU_CALL_RET_EN
    .pc_from_c(pc_from_c),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [20:0] obs;
  assign obs = {reset_pc, load_pc, pc_sel, addr_sel, mem_cmd, load_ir, load_addr,
                nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, halted};

  // One bit (or field value) per output, positioned as in obs.
  localparam logic [20:0] RPC  = 21'(1) << 20;
  localparam logic [20:0] LPC  = 21'(1) << 19;
  localparam logic [20:0] PCS  = 21'(1) << 18;
  localparam logic [20:0] ADR  = 21'(1) << 17;
  localparam logic [20:0] RD   = 21'(1) << 15;
  localparam logic [20:0] WRC  = 21'(2) << 15;
  localparam logic [20:0] LIR  = 21'(1) << 14;
  localparam logic [20:0] LAD  = 21'(1) << 13;
  localparam logic [20:0] NRN  = 21'(1) << 10;
  localparam logic [20:0] NRD  = 21'(2) << 10;
  localparam logic [20:0] NRM  = 21'(4) << 10;
  localparam logic [20:0] VPC  = 21'(1) << 8;
  localparam logic [20:0] VIMM = 21'(2) << 8;
  localparam logic [20:0] VMD  = 21'(3) << 8;
  localparam logic [20:0] WR   = 21'(1) << 7;
  localparam logic [20:0] LA   = 21'(1) << 6;
  localparam logic [20:0] LB   = 21'(1) << 5;
  localparam logic [20:0] LC   = 21'(1) << 4;
  localparam logic [20:0] LS   = 21'(1) << 3;
  localparam logic [20:0] AS   = 21'(1) << 2;
  localparam logic [20:0] BS   = 21'(1) << 1;
  localparam logic [20:0] HLT  = 21'(1);

  logic [20:0] exp_q[$];

  task automatic check_val(input string tag, input logic [20:0] got, input logic [20:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%06h want=%06h", tag, got, want);
    end
  endtask

  function automatic bit branch_taken(input logic [2:0] c, input logic n, input logic v, input logic z);
    bit lt;
    lt = (n != v);
    case (c)
      3'd0:    return 1'b1;          // B
      3'd1:    return z;             // BEQ
      3'd2:    return !z;            // BNE
      3'd3:    return lt;            // BLT
      3'd4:    return lt || z;       // BLE
      default: return 1'b0;
    endcase
  endfunction

  // Expected cycles after IF1: IF2, UPDATE_PC, DECODE, then the mnemonic's micro-ops.
  task automatic model_instr(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] c,
                             input logic n, input logic v, input logic z);
    exp_q.delete();
    exp_q.push_back(ADR | RD | LIR);
    exp_q.push_back(LPC);
    exp_q.push_back(21'(0));
    if (opc == 3'b110 && o == 2'b10) begin                  // MOV imm
      exp_q.push_back(NRN | VIMM | WR);
    end else if (opc == 3'b110 && o == 2'b00) begin         // MOV reg
      exp_q.push_back(NRM | LB); exp_q.push_back(LC | AS); exp_q.push_back(NRD | WR);
    end else if (opc == 3'b101 && o == 2'b11) begin         // MVN
      exp_q.push_back(NRM | LB); exp_q.push_back(LC); exp_q.push_back(NRD | WR);
    end else if (opc == 3'b101 && o == 2'b01) begin         // CMP
      exp_q.push_back(NRN | LA); exp_q.push_back(NRM | LB); exp_q.push_back(LS);
    end else if (opc == 3'b101) begin                       // ADD / AND
      exp_q.push_back(NRN | LA); exp_q.push_back(NRM | LB);
      exp_q.push_back(LC); exp_q.push_back(NRD | WR);
    end else if (opc == 3'b011 && o == 2'b00) begin         // LDR
      exp_q.push_back(NRN | LA); exp_q.push_back(BS | LC); exp_q.push_back(LAD);
      exp_q.push_back(RD); exp_q.push_back(RD | NRD | VMD | WR);
    end else if (opc == 3'b100 && o == 2'b00) begin         // STR
      exp_q.push_back(NRN | LA); exp_q.push_back(BS | LC); exp_q.push_back(LAD);
      exp_q.push_back(NRD | LB); exp_q.push_back(AS | LC); exp_q.push_back(WRC);
    end else if (opc == 3'b111) begin                       // HALT
      exp_q.push_back(HLT);
    end else if (opc == 3'b001) begin                       // B<cond>
      exp_q.push_back(branch_taken(c, n, v, z) ? (LPC | PCS) : 21'(0));
`ifdef CPU_CALL_RET_EN
    end else if (opc == 3'b010 && o == 2'b11) begin         // BL
      exp_q.push_back(NRN | VPC | WR | LPC | PCS);
    end else if (opc == 3'b010 && (o == 2'b10 || o == 2'b00)) begin  // BLX / BX
      if (o == 2'b10) exp_q.push_back(NRN | VPC | WR);
      exp_q.push_back(NRD | LB); exp_q.push_back(AS | LC); exp_q.push_back(LPC | PCS);
`endif
    end
  endtask

  // Checks IF1, then loads the instruction and checks up to max_cycles further cycles (<0: all).
  task automatic run_instr(input string name, input logic [2:0] opc, input logic [1:0] o,
                           input logic [2:0] c, input logic n, input logic v, input logic z,
                           input int max_cycles);
    int lim;
    @(posedge clk); #1;
    check_val({name, "_if1"}, obs, ADR | RD);
    opcode = opc; op = o; cond = c; N = n; V = v; Z = z;
    model_instr(opc, o, c, n, v, z);
    lim = (max_cycles < 0) ? exp_q.size() : max_cycles;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      check_val($sformatf("%s_c%0d", name, i + 2), obs, exp_q[i]);
    end
  endtask

  initial begin
    logic [2:0] r_opc;
    logic [1:0] r_op;
    logic [2:0] r_cond;

    repeat (3) @(posedge clk);
    #1 check_val("rst_hold", obs, RPC | LPC);
    @(negedge clk) reset = 1'b0;

    run_instr("mov_imm", 3'b110, 2'b10, 3'd0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("ldr",     3'b011, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("str",     3'b100, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("cmp1",    3'b101, 2'b01, 3'd0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("blt_tk",  3'b001, 2'b00, 3'd3, 1'b1, 1'b0, 1'b0, -1);
    run_instr("cmp2",    3'b101, 2'b01, 3'd0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("blt_nt",  3'b001, 2'b00, 3'd3, 1'b0, 1'b0, 1'b0, -1);
    run_instr("ble_z",   3'b001, 2'b00, 3'd4, 1'b0, 1'b0, 1'b1, -1);
    run_instr("nop",     3'b000, 2'b01, 3'd0, 1'b0, 1'b0, 1'b0, -1);

    for (int k = 0; k < 80; k++) begin
      r_opc  = 3'($urandom_range(0, 6));
      r_op   = 2'($urandom);
      r_cond = 3'($urandom);
      run_instr($sformatf("rnd%0d_%0d%0d", k, r_opc, r_op), r_opc, r_op, r_cond,
                1'($urandom), 1'($urandom), 1'($urandom), -1);
    end

    // Reset asserted mid-GET_B of a MOV reg must take effect without a clock edge.
    run_instr("movr_cut", 3'b110, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 4);
    reset = 1'b1;
    #1 check_val("async_rst", obs, RPC | LPC);
    @(posedge clk); #1 check_val("rst_after_cut", obs, RPC | LPC);
    @(negedge clk) reset = 1'b0;

    run_instr("halt", 3'b111, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, -1);
    for (int k = 0; k < 100; k++) begin
      opcode = 3'($urandom); op = 2'($urandom); cond = 3'($urandom);
      @(posedge clk); #1;
      check_val($sformatf("halt_hold%0d", k), obs, HLT);
    end
    reset = 1'b1;
    #1 check_val("halt_rst", obs, RPC | LPC);
    @(negedge clk) reset = 1'b0;
    run_instr("post_halt", 3'b110, 2'b10, 3'd0, 1'b0, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
